// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared widths, constants and the prefetch entry type.
// Rev 1.0
`default_nettype none

package if_fetch_unit_pkg;

  localparam int WORD_LEN = 32;
  localparam logic [WORD_LEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [WORD_LEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_LEN-1:0] pc;
    logic [WORD_LEN-1:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_sync_fifo.sv
// if_sync_fifo: small synchronous FIFO with flush; push and pop may coincide when full.
// Rev 1.0
`default_nettype none

module if_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: sequential instruction fetch with prefetch buffer, stall and redirect.
// Rev 1.0
`default_nettype none

module if_fetch_unit #(
  parameter int                     WORD_LEN        = if_fetch_unit_pkg::WORD_LEN,
  parameter logic [WORD_LEN-1:0]    RESET_PC        = if_fetch_unit_pkg::RESET_PC_DEFAULT,
  parameter int                     PF_DEPTH        = 2,
  parameter int                     MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                freeze,
  input  logic                redirect,
  input  logic [WORD_LEN-1:0] redirect_pc,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [WORD_LEN-1:0] imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [WORD_LEN-1:0] imem_rsp_data,
  output logic [WORD_LEN-1:0] pc_out,
  output logic [WORD_LEN-1:0] instruction_out,
  output logic                fetch_valid
);

  import if_fetch_unit_pkg::*;

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PW = $clog2(PF_DEPTH) + 1;
  localparam int SW = ((OW > PW) ? OW : PW) + 1;

  logic [WORD_LEN-1:0] fetch_pc;
  logic [OW-1:0]       outstanding;
  logic [OW-1:0]       discard;
  logic                running;
  logic [PW-1:0]       pf_count;
  logic                pf_full;
  logic                pf_empty;
  logic                pf_pop;
  logic                pcq_full;
  logic                pcq_empty;
  logic [WORD_LEN-1:0] pcq_dout;
  logic [SW-1:0]       occupancy;
  logic                issue;
  logic                rsp_take;
  logic                rsp_drop;
  logic                rsp_keep;
  fetch_entry_t        pf_din;
  fetch_entry_t        pf_dout;

  // Reserve buffer space for every live request so responses can always land.
  assign occupancy      = SW'(pf_count) + SW'(outstanding) - SW'(discard);
  assign imem_req_valid = running && !redirect && !pcq_full && !pf_full
                          && (occupancy < SW'(PF_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign issue          = imem_req_valid && imem_req_ready;

  assign rsp_take = imem_rsp_valid && !pcq_empty;
  assign rsp_drop = rsp_take && (redirect || (discard != '0));
  assign rsp_keep = rsp_take && !rsp_drop;

  assign pf_din.pc    = pcq_dout;
  assign pf_din.instr = imem_rsp_data;

  assign fetch_valid     = !pf_empty;
  assign pc_out          = fetch_valid ? pf_dout.pc : '0;
  assign instruction_out = fetch_valid ? pf_dout.instr : NOP_INSTR;
  assign pf_pop          = fetch_valid && !freeze;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc <= RESET_PC;
      discard  <= '0;
      running  <= 1'b0;
    end else begin
      running <= 1'b1;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        discard  <= outstanding - OW'(rsp_take);
      end else begin
        if (issue)    fetch_pc <= fetch_pc + WORD_LEN'(4);
        if (rsp_drop) discard  <= discard - OW'(1);
      end
    end
  end

  // Queue depth doubles as the outstanding-request count.
  if_sync_fifo #(
    .WIDTH (WORD_LEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_queue (
    .clk   (clk),
    .rstn  (rstn),
    .push  (issue),
    .pop   (rsp_take),
    .clear (1'b0),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (outstanding),
    .din   (fetch_pc),
    .dout  (pcq_dout)
  );

  if_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (PF_DEPTH)
  ) u_prefetch (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rsp_keep),
    .pop   (pf_pop),
    .clear (redirect),
    .full  (pf_full),
    .empty (pf_empty),
    .count (pf_count),
    .din   (pf_din),
    .dout  (pf_dout)
  );

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed and randomised-memory checks of the fetch stream.
// Rev 1.0
`default_nettype none

module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn;
  logic        freeze;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        fetch_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pops  = 0;

  logic        rand_ready = 1'b0;
  logic        rand_lat   = 1'b0;
  int          fixed_lat  = 1;
  int          lat_v;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t        q[$];
  req_t        r;
  logic [31:0] issued_log[$];

  logic [31:0] exp_pc = 32'h0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc = 32'h0;

  if_fetch_unit dut (
    .clk             (clk),
    .rstn            (rstn),
    .freeze          (freeze),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .fetch_valid     (fetch_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory: in-order responses, each at least its latency after acceptance.
  always @(negedge clk) begin
    if (!rstn) begin
      q.delete();
    end else begin
      if (imem_rsp_valid) begin
        assert (q.size() > 0) else $error("response with nothing outstanding");
        if (q.size() > 0) void'(q.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        lat_v  = rand_lat ? int'($urandom_range(1, 4)) : fixed_lat;
        r.addr = imem_req_addr;
        r.due  = cyc + lat_v;
        q.push_back(r);
        if (issued_log.size() < 3) issued_log.push_back(imem_req_addr);
        chk("outstanding_max", 32'(q.size() <= 2), 32'd1);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rstn && q.size() > 0 && q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Architectural model: the presented stream is RESET_PC, +4 per pop, restarted by redirect.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_pc    = 32'h0;
      prev_hold = 1'b0;
    end else begin
      if (fetch_valid) begin
        chk("pc_out", pc_out, exp_pc);
        chk("instruction_out", instruction_out, instr_of(exp_pc));
      end else begin
        chk("bubble_pc", pc_out, 32'h0);
        chk("bubble_instr", instruction_out, NOP);
      end
      if (prev_hold) begin
        chk("freeze_hold_valid", 32'(fetch_valid), 32'd1);
        chk("freeze_hold_pc", pc_out, prev_pc);
      end
      if (redirect) chk("no_issue_on_redirect", 32'(imem_req_valid), 32'd0);
      prev_hold = fetch_valid && freeze && !redirect;
      prev_pc   = pc_out;
      if (redirect) begin
        exp_pc = redirect_pc;
      end else if (fetch_valid && !freeze) begin
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
  end

  task automatic wait_valid(input string name, input logic [31:0] want_pc);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (fetch_valid) seen = 1;
    end
    chk({name, "_seen"}, 32'(seen), 32'd1);
    if (seen) chk({name, "_pc"}, pc_out, want_pc);
    tick(1);
  endtask

  initial begin
    int p0;
    bit two_out;
    rstn = 1'b0; freeze = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    tick(2);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_instr", instruction_out, NOP);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    #1 rstn = 1'b1;

    // Startup latency: valid first seen after the third edge.
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("startup_not_yet", 32'(fetch_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("startup_valid", 32'(fetch_valid), 32'd1);
    chk("startup_pc", pc_out, 32'h0);
    tick(6);
    chk("req0", (issued_log.size() > 0) ? issued_log[0] : 32'hFFFF_FFFF, 32'h0);
    chk("req1", (issued_log.size() > 1) ? issued_log[1] : 32'hFFFF_FFFF, 32'h4);
    chk("req2", (issued_log.size() > 2) ? issued_log[2] : 32'hFFFF_FFFF, 32'h8);

    // Freeze for five cycles.
    p0 = pops;
    freeze = 1'b1;
    tick(4);
    @(negedge clk);
    chk("freeze_req_blocked", 32'(imem_req_valid), 32'd0);
    chk("freeze_valid", 32'(fetch_valid), 32'd1);
    tick(1);
    freeze = 1'b0;
    tick(6);
    chk("freeze_resume", 32'(pops - p0 >= 4), 32'd1);

    // Redirect with two requests in flight at latency 3.
    fixed_lat = 3;
    two_out = 0;
    for (int i = 0; i < 30 && !two_out; i++) begin
      tick(1);
      if (q.size() == 2) two_out = 1;
    end
    chk("two_outstanding_reached", 32'(two_out), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick(1);
    redirect = 1'b0;
    @(negedge clk);
    chk("redirect_flushed", 32'(fetch_valid), 32'd0);
    wait_valid("redirect_target", 32'h0000_0100);

    // Redirect together with freeze on a full buffer.
    fixed_lat = 1;
    tick(2);
    freeze = 1'b1;
    tick(3);
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick(1);
    redirect = 1'b0; freeze = 1'b0;
    @(negedge clk);
    chk("redir_freeze_flushed", 32'(fetch_valid), 32'd0);
    wait_valid("redir_freeze_target", 32'h0000_0200);

    // Random ready and latency.
    rand_ready = 1'b1; rand_lat = 1'b1;
    p0 = pops;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      freeze = ($urandom_range(0, 4) == 0);
    end
    freeze = 1'b0; rand_ready = 1'b0; rand_lat = 1'b0;
    tick(8);
    chk("random_progress", 32'(pops - p0 >= 30), 32'd1);

    // Asynchronous reset while the buffer is full.
    freeze = 1'b1;
    tick(4);
    @(negedge clk);
    chk("prereset_full_valid", 32'(fetch_valid), 32'd1);
    chk("prereset_req_blocked", 32'(imem_req_valid), 32'd0);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("async_rst_valid", 32'(fetch_valid), 32'd0);
    chk("async_rst_pc", pc_out, 32'h0);
    chk("async_rst_instr", instruction_out, NOP);
    chk("async_rst_req", 32'(imem_req_valid), 32'd0);
    freeze = 1'b0;
    tick(2);
    #1 rstn = 1'b1;
    wait_valid("restart", 32'h0);
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that drives the pcIn/instructionIn side of the IF/ID pipeline register.
- Generates sequential PCs and issues requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions in a small prefetch FIFO and presents them to IF/ID.
- Honours freeze (stall) and branch redirect; any response already in flight for the old path is dropped.

Parameters:
- WORD_LEN, 32 (from defines package), address/instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- PF_DEPTH, 2, prefetch FIFO entries (power of 2, >=2)
- MAX_OUTSTANDING, 2, maximum issued-but-unanswered memory requests

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous assert, active-low
- freeze  in  1  downstream stall; head entry must be held
- redirect  in  1  branch/jump taken, restart fetch at redirect_pc
- redirect_pc  in  WORD_LEN  new fetch address, word-aligned
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  WORD_LEN  request address
- imem_rsp_valid  in  1  response valid, in order, latency >=1 cycle
- imem_rsp_data  in  WORD_LEN  instruction word
- pc_out  out  WORD_LEN  PC of presented instruction
- instruction_out  out  WORD_LEN  presented instruction
- fetch_valid  out  1  pc_out/instruction_out hold a real instruction

Behaviour:
- Reset (async, rstn=0):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0.
  - imem_req_valid=0, fetch_valid=0, pc_out=0, instruction_out=NOP_INSTR (32'h0000_0013).
- Issue rule:
  - imem_req_valid=1 iff !redirect and outstanding<MAX_OUTSTANDING and (fifo_count+outstanding-discard)<PF_DEPTH.
  - imem_req_addr=fetch_pc.
  - On handshake (valid&ready): push fetch_pc into the in-flight PC queue, fetch_pc+=4 (wraps modulo 2^WORD_LEN), outstanding++.
- Response:
  - On imem_rsp_valid with discard>0: drop the response, discard--, outstanding--, pop the PC queue.
  - Otherwise: pop the PC queue and push {pc,data} into the FIFO; outstanding--.
- Output:
  - FIFO non-empty: fetch_valid=1 and head is presented combinationally.
  - FIFO empty: fetch_valid=0, pc_out=0, instruction_out=NOP_INSTR (bubble into IF/ID).
  - Head is popped when fetch_valid & !freeze.
  - Response-to-output latency is 1 cycle through the FIFO (registered write, read next cycle). No FIFO bypass.
- Redirect (single cycle):
  - Next cycle: fetch_pc=redirect_pc; FIFO cleared; discard = outstanding after this cycle's response is accounted.
  - A response arriving in the redirect cycle is dropped.
  - No request is issued in the redirect cycle.
- Simultaneous events:
  - redirect and freeze: redirect wins, FIFO flushed.
  - Pop and push in the same cycle are both legal when full-1/full.
  - Issue and response in the same cycle: outstanding unchanged.
- Freeze:
  - Head is held stable.
  - Issue continues until the buffer-space rule blocks it; responses still land in the FIFO, which space reservation guarantees.
- Protocol errors: imem_rsp_valid with outstanding==0 is ignored, and the bench asserts on it.
- Mid-operation reset: all state cleared immediately; responses to pre-reset requests must not arrive. The memory model is reset by the same rstn.

Decomposition:
- defines package gets NOP_INSTR, RESET_PC default, and a typedef fetch_entry_t {pc, instr} packed struct.
- Sub-module if_sync_fifo (parameters WIDTH, DEPTH; ports push, pop, clear, full, empty, count, din, dout; async active-low reset). It is instantiated twice:
  - in-flight PC queue, depth MAX_OUTSTANDING, width WORD_LEN
  - prefetch FIFO, depth PF_DEPTH, width of fetch_entry_t

Test Plan:
- Reset release, mem ready always, 1-cycle latency, freeze=0 -> requests at 0,4,8,...; first fetch_valid at cycle 3 with pc_out=0, then one instruction per cycle, pc_out incrementing by 4.
- freeze held 5 cycles while streaming -> pc_out/instruction_out stable; imem_req_valid drops once fifo_count+outstanding==2; no instruction lost or duplicated after release.
- redirect to 32'h0000_0100 with 2 requests outstanding (latency 3) -> both stale responses dropped, FIFO empty next cycle, fetch_valid=0 (NOP) until pc_out=32'h100 appears.
- redirect and freeze asserted in the same cycle -> FIFO flushed, next valid pc_out=redirect_pc.
- imem_req_ready random 50% with latency random 1-4 -> output PC sequence strictly +4 per pop, no gaps, outstanding never exceeds 2.
- rstn pulsed low mid-stream with FIFO full -> outputs go to reset values asynchronously; after release fetch restarts at RESET_PC.
